barrel_shift_pipe: RTL and testbench

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/shift_pkg.sv | 32 +++
 rtl/shift_stage.sv | 45 ++++
 rtl/barrel_shift_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the barrel shifter pipeline: shift types, operand
// mode constants, the packed op word, and elaboration helpers that map
// log-shifter levels onto pipeline register stages.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_type_t;

    localparam logic MODE_IMM = 1'b0;
    localparam logic MODE_REG = 1'b1;

    // Matches the in_op port layout: [2:1] type, [0] mode.
    typedef struct packed {
        sh_type_t kind;
        logic     mode;
    } shift_op_t;

    // Pipeline stage that owns a given mux level (levels spread evenly).
    function automatic int stage_of(input int level, input int levels, input int stages);
        return (level * stages) / levels;
    endfunction

    // First mux level belonging to a stage; first_level(stages) == levels.
    function automatic int first_level(input int stage, input int levels, input int stages);
        return (stage * levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the logarithmic shifter: optionally shifts/rotates by the
// fixed power-of-two SHIFT and tracks the last bit moved out as carry.
import shift_pkg::*;

module shift_stage #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic             en,
    input  sh_type_t         kind,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_carry,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry
);

    // Pass-through when this level's amount bit is clear; otherwise apply
    // the shift and take the final shifted-out bit as the new carry.
    always_comb begin
        res_data  = src_data;
        res_carry = src_carry;
        if (en) begin
            case (kind)
                SH_LSL: begin
                    res_data  = src_data << SHIFT;
                    res_carry = src_data[WIDTH-SHIFT];
                end
                SH_LSR: begin
                    res_data  = src_data >> SHIFT;
                    res_carry = src_data[SHIFT-1];
                end
                SH_ASR: begin
                    res_data  = WIDTH'($signed(src_data) >>> SHIFT);
                    res_carry = src_data[SHIFT-1];
                end
                SH_ROR: begin
                    res_data  = {src_data[SHIFT-1:0], src_data[WIDTH-1:SHIFT]};
                    res_carry = src_data[SHIFT-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR/RRX with carry-out).
// Amount decode resolves every special case up front, so the log2(WIDTH)
// mux levels only ever see a plain in-range shift. Levels are spread over
// STAGES register banks that all stall together on output back-pressure.
// Optional feature macro BARREL_SHIFT_NZ_EN adds registered out_n / out_z.
import shift_pkg::*;

module barrel_shift_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_amt,
    input  logic [2:0]       in_op,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
`ifdef BARREL_SHIFT_NZ_EN
    ,
    output logic             out_n,
    output logic             out_z
`endif
);

    localparam int L = $clog2(WIDTH);
    localparam logic [7:0] W_AMT = 8'(WIDTH);

    shift_op_t        op;
    logic             amt_zero;
    logic             advance;
    logic [WIDTH-1:0] dec_data;
    logic             dec_carry;
    logic [L-1:0]     dec_amt;

    // Per-level mux inputs/outputs; the amount is consumed LSB first and
    // shifted down one bit per level.
    logic [WIDTH-1:0] src_data  [L];
    logic             src_carry [L];
    sh_type_t         src_kind  [L];
    logic [L-1:0]     src_amt   [L];
    logic [L-1:0]     nxt_amt   [L];
    logic [WIDTH-1:0] res_data  [L];
    logic             res_carry [L];

    // Register banks, one per pipeline stage.
    logic             valid_src [STAGES];
    logic             valid_reg [STAGES];
    logic [WIDTH-1:0] data_reg  [STAGES];
    logic             carry_reg [STAGES];
    sh_type_t         kind_reg  [STAGES];
    logic [L-1:0]     amt_reg   [STAGES];

    assign op        = shift_op_t'(in_op);
    assign amt_zero  = (in_amt == 8'd0);
    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];
    assign out_carry = carry_reg[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // Amount decode: remap immediate-zero and overrange cases into a forced
    // operand/carry with zero residual shift so the levels just pass it.
    always_comb begin
        dec_data  = in_data;
        dec_carry = in_carry;
        dec_amt   = in_amt[L-1:0];
        case (op.kind)
            SH_LSL: begin
                if (in_amt > W_AMT) begin
                    dec_data  = '0;
                    dec_carry = 1'b0;
                    dec_amt   = '0;
                end else if (in_amt == W_AMT) begin
                    dec_data  = '0;
                    dec_carry = in_data[0];
                    dec_amt   = '0;
                end
            end
            SH_LSR: begin
                if ((op.mode == MODE_IMM && amt_zero) || in_amt == W_AMT) begin
                    dec_data  = '0;
                    dec_carry = in_data[WIDTH-1];
                    dec_amt   = '0;
                end else if (in_amt > W_AMT) begin
                    dec_data  = '0;
                    dec_carry = 1'b0;
                    dec_amt   = '0;
                end
            end
            SH_ASR: begin
                if ((op.mode == MODE_IMM && amt_zero) || in_amt >= W_AMT) begin
                    dec_data  = {WIDTH{in_data[WIDTH-1]}};
                    dec_carry = in_data[WIDTH-1];
                    dec_amt   = '0;
                end
            end
            SH_ROR: begin
                if (op.mode == MODE_IMM && amt_zero) begin
                    // RRX: rotate one place through the incoming carry.
                    dec_data  = {in_carry, in_data[WIDTH-1:1]};
                    dec_carry = in_data[0];
                    dec_amt   = '0;
                end else if (op.mode == MODE_REG && amt_zero) begin
                    dec_amt   = '0;
                end else if (in_amt[L-1:0] == '0) begin
                    // Whole-word rotation: data unchanged, carry is the MSB.
                    dec_carry = in_data[WIDTH-1];
                    dec_amt   = '0;
                end
            end
            default: ;
        endcase
    end

    genvar gi;

    // Mux levels: level gi shifts by 2**gi and is fed either by the decode,
    // by the register bank in front of its stage, or by the previous level.
    generate
        for (gi = 0; gi < L; gi++) begin : g_level
            localparam int S = stage_of(gi, L, STAGES);
            if (gi == 0) begin : g_from_decode
                assign src_data[gi]  = dec_data;
                assign src_carry[gi] = dec_carry;
                assign src_kind[gi]  = op.kind;
                assign src_amt[gi]   = dec_amt;
            end else if (gi == first_level(S, L, STAGES)) begin : g_from_reg
                assign src_data[gi]  = data_reg[S-1];
                assign src_carry[gi] = carry_reg[S-1];
                assign src_kind[gi]  = kind_reg[S-1];
                assign src_amt[gi]   = amt_reg[S-1];
            end else begin : g_from_level
                assign src_data[gi]  = res_data[gi-1];
                assign src_carry[gi] = res_carry[gi-1];
                assign src_kind[gi]  = src_kind[gi-1];
                assign src_amt[gi]   = nxt_amt[gi-1];
            end
            assign nxt_amt[gi] = src_amt[gi] >> 1;

            shift_stage #(
                .WIDTH (WIDTH),
                .SHIFT (1 << gi)
            ) u_shift_stage (
                .en        (src_amt[gi][0]),
                .kind      (src_kind[gi]),
                .src_data  (src_data[gi]),
                .src_carry (src_carry[gi]),
                .res_data  (res_data[gi]),
                .res_carry (res_carry[gi])
            );
        end

        for (gi = 0; gi < STAGES; gi++) begin : g_bank
            localparam int LAST = first_level(gi + 1, L, STAGES) - 1;
            if (gi == 0) begin : g_valid_in
                assign valid_src[gi] = in_valid;
            end else begin : g_valid_chain
                assign valid_src[gi] = valid_reg[gi-1];
            end

            // Stage register: captures the last level of this stage; the
            // whole pipe freezes while the output is held.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    carry_reg[gi] <= 1'b0;
                    kind_reg[gi]  <= SH_LSL;
                    amt_reg[gi]   <= '0;
                end else if (advance) begin
                    valid_reg[gi] <= valid_src[gi];
                    data_reg[gi]  <= res_data[LAST];
                    carry_reg[gi] <= res_carry[LAST];
                    kind_reg[gi]  <= src_kind[LAST];
                    amt_reg[gi]   <= nxt_amt[LAST];
                end
            end
        end
    endgenerate

`ifdef BARREL_SHIFT_NZ_EN
    // Negative/zero flags, captured alongside the final data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_n <= 1'b0;
            out_z <= 1'b0;
        end else if (advance) begin
            out_n <= res_data[L-1][WIDTH-1];
            out_z <= (res_data[L-1] == '0);
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=32, STAGES=2):
// a directed vector table plus stall and mid-flight reset sequences.
module tb_barrel_shift_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [7:0]       in_amt;
    logic [2:0]       in_op;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
`ifdef BARREL_SHIFT_NZ_EN
    logic             out_n;
    logic             out_z;
`endif

    barrel_shift_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
`ifdef BARREL_SHIFT_NZ_EN
        ,
        .out_n     (out_n),
        .out_z     (out_z)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // op encoding: {type[1:0], mode}; mode 1 = register, 0 = immediate
    typedef struct {
        string       name;
        logic [31:0] data;
        logic [7:0]  amt;
        logic [2:0]  op;
        logic        cin;
        logic [31:0] exp_data;
        logic        exp_c;
    } vec_t;

    vec_t vecs [21];
    vec_t stall_v [4];

    task automatic drive(input vec_t v);
        in_data  = v.data;
        in_amt   = v.amt;
        in_op    = v.op;
        in_carry = v.cin;
    endtask

    initial begin
        vecs[0]  = '{"lsl_reg_4",      32'hF000000F, 8'd4,  3'b001, 1'b0, 32'h000000F0, 1'b1};
        vecs[1]  = '{"lsr_imm_0",      32'h80000001, 8'd0,  3'b010, 1'b0, 32'h00000000, 1'b1};
        vecs[2]  = '{"asr_reg_40",     32'h80000000, 8'd40, 3'b101, 1'b0, 32'hFFFFFFFF, 1'b1};
        vecs[3]  = '{"rrx",            32'h00000003, 8'd0,  3'b110, 1'b1, 32'h80000001, 1'b1};
        vecs[4]  = '{"ror_reg_36",     32'h00000010, 8'd36, 3'b111, 1'b0, 32'h00000001, 1'b0};
        vecs[5]  = '{"lsl_reg_0",      32'h12345678, 8'd0,  3'b001, 1'b1, 32'h12345678, 1'b1};
        vecs[6]  = '{"lsl_reg_32",     32'h00000001, 8'd32, 3'b001, 1'b0, 32'h00000000, 1'b1};
        vecs[7]  = '{"lsl_reg_33",     32'hFFFFFFFF, 8'd33, 3'b001, 1'b1, 32'h00000000, 1'b0};
        vecs[8]  = '{"lsr_reg_1",      32'h00000003, 8'd1,  3'b011, 1'b0, 32'h00000001, 1'b1};
        vecs[9]  = '{"lsr_reg_32",     32'h80000000, 8'd32, 3'b011, 1'b0, 32'h00000000, 1'b1};
        vecs[10] = '{"lsr_reg_40",     32'hFFFFFFFF, 8'd40, 3'b011, 1'b1, 32'h00000000, 1'b0};
        vecs[11] = '{"asr_reg_4",      32'h80000010, 8'd4,  3'b101, 1'b1, 32'hF8000001, 1'b0};
        vecs[12] = '{"asr_imm_0",      32'h7FFFFFFF, 8'd0,  3'b100, 1'b1, 32'h00000000, 1'b0};
        vecs[13] = '{"asr_reg_0",      32'h80000000, 8'd0,  3'b101, 1'b1, 32'h80000000, 1'b1};
        vecs[14] = '{"ror_reg_0",      32'hA5A5A5A5, 8'd0,  3'b111, 1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[15] = '{"ror_reg_64",     32'h80000001, 8'd64, 3'b111, 1'b0, 32'h80000001, 1'b1};
        vecs[16] = '{"ror_reg_8",      32'h12345678, 8'd8,  3'b111, 1'b1, 32'h78123456, 1'b0};
        vecs[17] = '{"lsl_imm_31",     32'h00000003, 8'd31, 3'b000, 1'b0, 32'h80000000, 1'b1};
        vecs[18] = '{"ror_imm_1",      32'h00000001, 8'd1,  3'b110, 1'b0, 32'h80000000, 1'b1};
        vecs[19] = '{"asr_reg_31",     32'h80000000, 8'd31, 3'b101, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[20] = '{"lsr_imm_0_msb0", 32'h7FFFFFFE, 8'd0,  3'b010, 1'b1, 32'h00000000, 1'b0};

        stall_v[0] = '{"s0_lsl", 32'h00000001, 8'd1,  3'b001, 1'b0, 32'h00000002, 1'b0};
        stall_v[1] = '{"s1_lsr", 32'h00000010, 8'd2,  3'b011, 1'b0, 32'h00000004, 1'b0};
        stall_v[2] = '{"s2_asr", 32'h80000008, 8'd3,  3'b101, 1'b0, 32'hF0000001, 1'b0};
        stall_v[3] = '{"s3_ror", 32'h1234ABCD, 8'd16, 3'b111, 1'b0, 32'hABCD1234, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        in_carry  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table: one request each, result expected 2 cycles later
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check({vecs[i].name, "_lat1_valid"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, "_data"},  out_data,       vecs[i].exp_data);
            check({vecs[i].name, "_carry"}, 32'(out_carry), 32'(vecs[i].exp_c));
            $display("[TB] %s data=0x%08h amt=%0d op=%b cin=%b -> out=0x%08h c=%b",
                     vecs[i].name, vecs[i].data, vecs[i].amt, vecs[i].op, vecs[i].cin,
                     out_data, out_carry);
        end

        // Back-pressure: 4 back-to-back requests, consumer stalls 3 cycles
        begin
            int sent = 0;
            int recv = 0;
            int cyc  = 0;
            while (recv < 4 && cyc < 40) begin
                @(negedge clk);
                in_valid = (sent < 4);
                if (sent < 4) drive(stall_v[sent]);
                out_ready = !(cyc >= 2 && cyc <= 4);
                #1;
                if (cyc >= 2 && cyc <= 4) begin
                    check("stall_in_ready",  32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_hold_data", out_data, stall_v[0].exp_data);
                end
                if (out_valid && out_ready) begin
                    check({stall_v[recv].name, "_data"},  out_data,       stall_v[recv].exp_data);
                    check({stall_v[recv].name, "_carry"}, 32'(out_carry), 32'(stall_v[recv].exp_c));
                    $display("[TB] stall result %0d (%s) out=0x%08h c=%b cycle=%0d",
                             recv, stall_v[recv].name, out_data, out_carry, cyc);
                    recv++;
                end
                if (in_valid && in_ready) sent++;
                cyc++;
            end
            check("stall_results_received", 32'(recv), 32'd4);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                #1;
                check("stall_no_duplicate", 32'(out_valid), 32'd0);
            end
        end

        // Reset with two requests in flight
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[16]);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid_before_rst", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data",  out_data,       32'd0);
        check("async_rst_out_carry", 32'(out_carry), 32'd0);
        $display("[TB] reset pulsed with 2 requests in flight");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            #1;
            check("no_stale_after_rst", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
